// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants and helpers for the VGA digit display:
//   - 640x480@60Hz horizontal/vertical timing limits (pixel/line counts)
//   - seven-segment rectangle geometry for the single large digit
//   - 10-entry abcdefg segment lookup and a rectangle hit-test helper
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal timing in pixels (counter runs 0..H_MAX)
  localparam cnt_t H_VISIBLE    = 10'd640;
  localparam cnt_t H_SYNC_START = 10'd656;
  localparam cnt_t H_SYNC_END   = 10'd751;
  localparam cnt_t H_MAX        = 10'd799;

  // Vertical timing in lines (counter runs 0..V_MAX)
  localparam cnt_t V_VISIBLE    = 10'd480;
  localparam cnt_t V_SYNC_START = 10'd490;
  localparam cnt_t V_SYNC_END   = 10'd491;
  localparam cnt_t V_MAX        = 10'd524;

  // Inclusive rectangle on the screen
  typedef struct packed {
    cnt_t x0;
    cnt_t x1;
    cnt_t y0;
    cnt_t y1;
  } rect_t;

  // Segment rectangles; index 6 = a ... index 0 = g, matching the
  // abcdefg bit order of seg_lut().
  localparam rect_t [6:0] SEG_RECT = '{
    rect_t'{10'd256, 10'd383, 10'd144, 10'd159},  // a
    rect_t'{10'd368, 10'd383, 10'd144, 10'd247},  // b
    rect_t'{10'd368, 10'd383, 10'd232, 10'd335},  // c
    rect_t'{10'd256, 10'd383, 10'd320, 10'd335},  // d
    rect_t'{10'd256, 10'd271, 10'd232, 10'd335},  // e
    rect_t'{10'd256, 10'd271, 10'd144, 10'd247},  // f
    rect_t'{10'd256, 10'd383, 10'd232, 10'd247}   // g
  };

  // Decimal digit -> abcdefg (bit 6 = a, 1 = lit)
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    return segs;
  endfunction

  function automatic logic in_rect(input cnt_t x, input cnt_t y, input rect_t r);
    return (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-enable divider plus 800x525 horizontal/vertical counters.
//   Sync, visible and frame_end outputs are combinational decodes of the
//   current counter values; the caller registers them on pix_en.
// Parameters
//   CLK_DIV      system clocks per pixel
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   pix_en_o     one-clk pulse every CLK_DIV clocks
//   hcnt_o       current pixel column 0..799
//   vcnt_o       current line 0..524
//   hsync_o      active-low horizontal sync decode of hcnt
//   vsync_o      active-low vertical sync decode of vcnt
//   visible_o    hcnt/vcnt inside the 640x480 active area
//   frame_end_o  pix_en on the last pixel of the frame
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pix_en_o,
  output cnt_t       hcnt_o,
  output cnt_t       vcnt_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o,
  output logic       frame_end_o
);

  // A one-bit divider still works for CLK_DIV == 1: it stays at 0 and
  // pix_en is permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  cnt_t             hcnt_q, hcnt_d;
  cnt_t             vcnt_q, vcnt_d;
  logic             pix_en;

  assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d  = div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      div_d = '0;
      if (hcnt_q == H_MAX) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign pix_en_o    = pix_en;
  assign hcnt_o      = hcnt_q;
  assign vcnt_o      = vcnt_q;
  assign hsync_o     = !((hcnt_q >= H_SYNC_START) && (hcnt_q <= H_SYNC_END));
  assign vsync_o     = !((vcnt_q >= V_SYNC_START) && (vcnt_q <= V_SYNC_END));
  assign visible_o   = (hcnt_q < H_VISIBLE) && (vcnt_q < V_VISIBLE);
  assign frame_end_o = pix_en && (hcnt_q == H_MAX) && (vcnt_q == V_MAX);

endmodule

// File: rtl/vga_digit_display_core.sv
// ---------------------------------------------------------------------------
// vga_digit_display_core
//   640x480@60Hz VGA generator drawing one large seven-segment decimal digit
//   centred on a black screen. The digit counts 0..9, stepping once every
//   DIGIT_FRAMES frames, always at a frame boundary.
// Parameters
//   CLK_DIV       system clocks per pixel (100 MHz -> 25 MHz pixel rate)
//   DIGIT_FRAMES  frames per digit step
//   FG_RGB        {R,G,B} colour of lit segments
// Build option
//   VGA_BORDER_EN  when defined, the outermost visible row/column on every
//                  side is drawn white, over the top of the digit.
// Ports
//   clk    system clock
//   reset  asynchronous active-high reset
//   hSync  horizontal sync, active low, registered
//   vSync  vertical sync, active low, registered
//   R/G/B  1-bit colour outputs, registered
// All outputs lag the pixel counters by one pixel period.
// ---------------------------------------------------------------------------
module vga_digit_display_core
  import vga_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter int         DIGIT_FRAMES = 60,
  parameter logic [2:0] FG_RGB       = 3'b010
) (
  input  logic clk,
  input  logic reset,
  output logic hSync,
  output logic vSync,
  output logic R,
  output logic G,
  output logic B
);

  localparam int FRAME_W = (DIGIT_FRAMES > 1) ? $clog2(DIGIT_FRAMES) : 1;

  logic       pix_en;
  cnt_t       hcnt, vcnt;
  logic       hsync_dec, vsync_dec, visible, frame_end;

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         digit_q, digit_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [2:0]         rgb_q, rgb_d;

  logic [6:0] seg_hit;
  logic       lit;
  logic [2:0] pix_rgb;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk_i       (clk),
    .rst_i       (reset),
    .pix_en_o    (pix_en),
    .hcnt_o      (hcnt),
    .vcnt_o      (vcnt),
    .hsync_o     (hsync_dec),
    .vsync_o     (vsync_dec),
    .visible_o   (visible),
    .frame_end_o (frame_end)
  );

  // One hit bit per segment rectangle, abcdefg order
  for (genvar gi = 0; gi < 7; gi++) begin : g_seg
    assign seg_hit[gi] = in_rect(hcnt, vcnt, SEG_RECT[gi]);
  end

  assign lit = |(seg_hit & seg_lut(digit_q));

`ifdef VGA_BORDER_EN
  logic border;
  assign border = (hcnt == '0) || (hcnt == H_VISIBLE - 10'd1) ||
                  (vcnt == '0) || (vcnt == V_VISIBLE - 10'd1);
  assign pix_rgb = !visible ? 3'b000 :
                   border   ? 3'b111 :
                   lit      ? FG_RGB : 3'b000;
`else
  assign pix_rgb = (visible && lit) ? FG_RGB : 3'b000;
`endif

  // Digit only steps on the last pixel of a frame, so a frame never shows
  // a mix of two digits.
  always_comb begin
    frame_d = frame_q;
    digit_d = digit_q;
    if (frame_end) begin
      if (frame_q == FRAME_W'(DIGIT_FRAMES - 1)) begin
        frame_d = '0;
        digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      hsync_d = hsync_dec;
      vsync_d = vsync_dec;
      rgb_d   = pix_rgb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      digit_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      frame_q <= frame_d;
      digit_q <= digit_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hSync = hsync_q;
  assign vSync = vsync_q;
  assign R     = rgb_q[2];
  assign G     = rgb_q[1];
  assign B     = rgb_q[0];

endmodule

// File: tb/tb_vga_digit_display_core.sv
// ---------------------------------------------------------------------------
// tb_vga_digit_display_core
//   Two instances share clock and reset:
//   - u_slow: default parameters, used for the 4-clk pixel timing of hSync
//   - u_fast: one clock per pixel and one frame per digit, so the full 0..9
//     digit cycle fits in a short run
//   Pixel (x,y) of frame f appears on the fast outputs after clock edge
//   f*420000 + y*800 + x + 1 counted from reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_digit_display_core;

  localparam int unsigned FRAME_CLKS = 420000;
  localparam logic [2:0]  FG         = 3'b010;
`ifdef VGA_BORDER_EN
  localparam logic [2:0]  BORDER_RGB = 3'b111;
`else
  localparam logic [2:0]  BORDER_RGB = 3'b000;
`endif

  typedef struct {
    int unsigned x;
    int unsigned y;
    int          seg_bit;
  } probe_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic s_hs, s_vs, s_r, s_g, s_b;
  logic f_hs, f_vs, f_r, f_g, f_b;

  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // abcdefg patterns for digits 0..9 (bit 6 = a)
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  // One interior pixel per segment, in raster order
  probe_t probes [7] = '{'{300, 150, 6},   // a
                         '{264, 200, 1},   // f
                         '{375, 200, 5},   // b
                         '{300, 240, 0},   // g
                         '{264, 280, 2},   // e
                         '{375, 280, 4},   // c
                         '{320, 328, 3}};  // d

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  vga_digit_display_core u_slow (
    .clk   (clk),
    .reset (reset),
    .hSync (s_hs),
    .vSync (s_vs),
    .R     (s_r),
    .G     (s_g),
    .B     (s_b)
  );

  vga_digit_display_core #(
    .CLK_DIV      (1),
    .DIGIT_FRAMES (1)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .hSync (f_hs),
    .vSync (f_vs),
    .R     (f_r),
    .G     (f_g),
    .B     (f_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic int unsigned px_cyc(input int unsigned fr, input int unsigned x,
                                         input int unsigned y);
    return fr * FRAME_CLKS + y * 800 + x + 1;
  endfunction

  // Advance to the falling edge after clock edge t (counted from release)
  task automatic wait_to(input int unsigned t);
    if (cyc > t) check("sample_late", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic sync_checks(input string pfx);
    wait_to(656);  check($sformatf("%s_fast_hs_655", pfx), 32'(f_hs), 32'd1);
    wait_to(657);  check($sformatf("%s_fast_hs_656", pfx), 32'(f_hs), 32'd0);
    wait_to(752);  check($sformatf("%s_fast_hs_751", pfx), 32'(f_hs), 32'd0);
    wait_to(753);  check($sformatf("%s_fast_hs_752", pfx), 32'(f_hs), 32'd1);
    wait_to(2627); check($sformatf("%s_slow_hs_pre_fall", pfx), 32'(s_hs), 32'd1);
    wait_to(2628); check($sformatf("%s_slow_hs_fall", pfx), 32'(s_hs), 32'd0);
    wait_to(3011); check($sformatf("%s_slow_hs_low_end", pfx), 32'(s_hs), 32'd0);
    wait_to(3012); check($sformatf("%s_slow_hs_rise", pfx), 32'(s_hs), 32'd1);
    check($sformatf("%s_slow_vs", pfx), 32'(s_vs), 32'd1);
    check($sformatf("%s_slow_rgb", pfx), 32'({s_r, s_g, s_b}), 32'd0);
    wait_to(5827); check($sformatf("%s_slow_hs_pre_fall2", pfx), 32'(s_hs), 32'd1);
    wait_to(5828); check($sformatf("%s_slow_hs_fall2", pfx), 32'(s_hs), 32'd0);
  endtask

  task automatic reset_state_checks(input string pfx);
    check($sformatf("%s_slow_hs", pfx), 32'(s_hs), 32'd1);
    check($sformatf("%s_slow_vs", pfx), 32'(s_vs), 32'd1);
    check($sformatf("%s_slow_rgb", pfx), 32'({s_r, s_g, s_b}), 32'd0);
    check($sformatf("%s_fast_hs", pfx), 32'(f_hs), 32'd1);
    check($sformatf("%s_fast_vs", pfx), 32'(f_vs), 32'd1);
    check($sformatf("%s_fast_rgb", pfx), 32'({f_r, f_g, f_b}), 32'd0);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_rgb;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset_state_checks("rst");
    @(negedge clk);
    reset = 1'b0;

    wait_to(1);
    check("f0_px_0_0", 32'({f_r, f_g, f_b}), 32'(BORDER_RGB));
    check("slow_hs_after_release", 32'(s_hs), 32'd1);

    sync_checks("run");

    for (int fr = 0; fr <= 10; fr++) begin
      if (fr > 0) begin
        wait_to(px_cyc(fr, 0, 0));
        check($sformatf("f%0d_px_0_0", fr), 32'({f_r, f_g, f_b}), 32'(BORDER_RGB));
      end else begin
        wait_to(px_cyc(0, 200, 100));
        check("f0_px_200_100_black", 32'({f_r, f_g, f_b}), 32'd0);
        wait_to(px_cyc(0, 700, 100));
        check("f0_px_700_100_blank", 32'({f_r, f_g, f_b}), 32'd0);
      end
      for (int p = 0; p < 7; p++) begin
        wait_to(px_cyc(fr, probes[p].x, probes[p].y));
        exp_rgb = seg_tab[fr % 10][probes[p].seg_bit] ? FG : 3'b000;
        check($sformatf("f%0d_d%0d_px_%0d_%0d", fr, fr % 10, probes[p].x, probes[p].y),
              32'({f_r, f_g, f_b}), 32'(exp_rgb));
      end
      wait_to(px_cyc(fr, 799, 489));
      check($sformatf("f%0d_vs_489", fr), 32'(f_vs), 32'd1);
      wait_to(px_cyc(fr, 0, 490));
      check($sformatf("f%0d_vs_490", fr), 32'(f_vs), 32'd0);
      wait_to(px_cyc(fr, 799, 491));
      check($sformatf("f%0d_vs_491", fr), 32'(f_vs), 32'd0);
      wait_to(px_cyc(fr, 0, 492));
      check($sformatf("f%0d_vs_492", fr), 32'(f_vs), 32'd1);
    end

    // Frame 11 shows digit 1; segment b is lit at (375,200)
    wait_to(px_cyc(11, 375, 200));
    check("f11_px_375_200_pre_reset", 32'({f_r, f_g, f_b}), 32'(FG));
    #2;
    reset = 1'b1;
    #1;
    reset_state_checks("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    sync_checks("restart");
    wait_to(px_cyc(0, 300, 150));
    check("restart_px_300_150", 32'({f_r, f_g, f_b}), 32'(FG));
    wait_to(px_cyc(0, 300, 240));
    check("restart_px_300_240", 32'({f_r, f_g, f_b}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
